// File: rtl/wb_stage.sv
// wb_stage -- write-back stage of the 5-stage MIPS pipeline.
//
// Latches the memory-stage bundle, commits GPR writes, owns the CP0
// register set (BadVAddr, Count, Compare, Status, Cause, EPC), executes
// MTC0/MFC0/ERET, arbitrates exceptions and interrupts and drives the
// pipeline-wide flush and redirect target.
//
// Optional feature macro: WB_TIMER_INT_EN
//   defined   : Count ticks every second cycle, Compare match raises TI on IP7.
//   undefined : Count/Compare read 0 and ignore writes, TI is always 0.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   ws_allowin         always 1 (WB never stalls)
//   ms_to_ws_valid/bus memory-stage bundle (122 bits, see field unpack below)
//   ext_int_in         external interrupt levels -> Cause.IP[15:10]
//   ws_to_rf_bus       {we, waddr, wdata} register-file write port
//   ws_to_ds_bus       {we, dest, data} forwarding bus, zero unless writing
//   exc_flush          flush earlier stages and redirect fetch
//   exc_target         redirect PC (exception vector or EPC for ERET)
//   debug_wb_*         commit trace
module wb_stage #(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380
) (
  input  logic         clk,
  input  logic         reset,
  output logic         ws_allowin,
  input  logic         ms_to_ws_valid,
  input  logic [121:0] ms_to_ws_bus,
  input  logic [5:0]   ext_int_in,
  output logic [37:0]  ws_to_rf_bus,
  output logic [37:0]  ws_to_ds_bus,
  output logic         exc_flush,
  output logic [31:0]  exc_target,
  output logic [31:0]  debug_wb_pc,
  output logic [3:0]   debug_wb_rf_wen,
  output logic [4:0]   debug_wb_rf_wnum,
  output logic [31:0]  debug_wb_rf_wdata
);

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_BP   = 5'd9;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_OV   = 5'd12;

  logic         ws_valid_q, ws_valid_d;
  logic [121:0] bus_q, bus_d;

  // CP0 state
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;
  logic        ti_q, ti_d;
  logic [7:0]  status_im_q, status_im_d;
  logic        status_exl_q, status_exl_d;
  logic        status_ie_q, status_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_hw_q, cause_ip_hw_d;
  logic [1:0]  cause_ip_sw_q, cause_ip_sw_d;
  logic [4:0]  cause_exccode_q, cause_exccode_d;
  logic [31:0] epc_q, epc_d;

  // Bundle fields
  logic        f_ov, f_ades, f_adel_if, f_adel_ld, f_ri, f_bp, f_flush, f_bd;
  logic        f_eret, f_sysc, f_mfc0, f_mtc0, f_gpr_we;
  logic [31:0] f_badvaddr, f_result, f_pc;
  logic [2:0]  f_sel;
  logic [4:0]  f_rd, f_dest;

  assign f_ov       = bus_q[121];
  assign f_badvaddr = bus_q[120:89];
  assign f_ades     = bus_q[88];
  assign f_adel_if  = bus_q[87];
  assign f_adel_ld  = bus_q[86];
  assign f_ri       = bus_q[85];
  assign f_bp       = bus_q[84];
  assign f_flush    = bus_q[83];
  assign f_bd       = bus_q[82];
  assign f_eret     = bus_q[81];
  assign f_sysc     = bus_q[80];
  assign f_mfc0     = bus_q[79];
  assign f_mtc0     = bus_q[78];
  assign f_sel      = bus_q[77:75];
  assign f_rd       = bus_q[74:70];
  assign f_gpr_we   = bus_q[69];
  assign f_dest     = bus_q[68:64];
  assign f_result   = bus_q[63:32];
  assign f_pc       = bus_q[31:0];

  logic [31:0] status_val, cause_val, cp0_rdata, rf_wdata;
  logic [7:0]  cause_ip;
  logic        live, int_pend, exc, eret_go, mtc0_go, rf_we;
  logic [4:0]  exc_code;
  logic        badv_we;
  logic [31:0] badv_val;

  assign cause_ip   = {cause_ip_hw_q, cause_ip_sw_q};
  assign status_val = {9'd0, 1'b1, 6'd0, status_im_q, 6'd0, status_exl_q, status_ie_q};
  assign cause_val  = {cause_bd_q, ti_q, 14'd0, cause_ip, 1'b0, cause_exccode_q, 2'b00};

  assign live     = ws_valid_q & ~f_flush;
  assign int_pend = status_ie_q & ~status_exl_q & (|(cause_ip & status_im_q));
  assign exc      = live & (int_pend | f_ov | f_ades | f_adel_if | f_adel_ld |
                            f_ri | f_bp | f_sysc);
  assign eret_go  = live & f_eret & ~exc;
  assign mtc0_go  = live & f_mtc0 & ~exc & (f_sel == 3'd0);
  assign rf_we    = live & f_gpr_we & ~exc;

  // Pipeline register next state: WB always accepts, so valid simply follows.
  always_comb begin
    ws_valid_d = ms_to_ws_valid;
    if (ms_to_ws_valid && ws_allowin) begin
      bus_d = ms_to_ws_bus;
    end else begin
      bus_d = bus_q;
    end
  end

  // CP0 read mux; reads see the pre-write value of the current cycle.
  always_comb begin
    cp0_rdata = 32'd0;
    if (f_sel == 3'd0) begin
      case (f_rd)
        5'd8:    cp0_rdata = badvaddr_q;
        5'd9:    cp0_rdata = count_q;
        5'd11:   cp0_rdata = compare_q;
        5'd12:   cp0_rdata = status_val;
        5'd13:   cp0_rdata = cause_val;
        5'd14:   cp0_rdata = epc_q;
        default: cp0_rdata = 32'd0;
      endcase
    end else begin
      cp0_rdata = 32'd0;
    end
  end

  assign rf_wdata = f_mfc0 ? cp0_rdata : f_result;

  // Exception priority encoder; interrupts beat every synchronous cause.
  always_comb begin
    exc_code = CODE_INT;
    badv_we  = 1'b0;
    badv_val = f_badvaddr;
    if (int_pend) begin
      exc_code = CODE_INT;
    end else if (f_adel_if) begin
      exc_code = CODE_ADEL;
      badv_we  = 1'b1;
      badv_val = f_pc;
    end else if (f_ri) begin
      exc_code = CODE_RI;
    end else if (f_ov) begin
      exc_code = CODE_OV;
    end else if (f_sysc) begin
      exc_code = CODE_SYS;
    end else if (f_bp) begin
      exc_code = CODE_BP;
    end else if (f_adel_ld) begin
      exc_code = CODE_ADEL;
      badv_we  = 1'b1;
    end else if (f_ades) begin
      exc_code = CODE_ADES;
      badv_we  = 1'b1;
    end else begin
      exc_code = CODE_INT;
    end
  end

  // CP0 next state: timer, exception entry, MTC0 and ERET.
  always_comb begin
    badvaddr_d      = badvaddr_q;
    status_im_d     = status_im_q;
    status_exl_d    = status_exl_q;
    status_ie_d     = status_ie_q;
    cause_bd_d      = cause_bd_q;
    cause_ip_sw_d   = cause_ip_sw_q;
    cause_exccode_d = cause_exccode_q;
    epc_d           = epc_q;
    cause_ip_hw_d   = {ext_int_in[5] | ti_q, ext_int_in[4:0]};
`ifdef WB_TIMER_INT_EN
    tick_d    = ~tick_q;
    count_d   = tick_q ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    ti_d      = ti_q | (count_q == compare_q);
`else
    tick_d    = 1'b0;
    count_d   = 32'd0;
    compare_d = 32'd0;
    ti_d      = 1'b0;
`endif
    if (exc) begin
      // A nested exception keeps the original EPC/BD.
      if (!status_exl_q) begin
        epc_d      = f_bd ? f_pc - 32'd4 : f_pc;
        cause_bd_d = f_bd;
      end else begin
        epc_d      = epc_q;
        cause_bd_d = cause_bd_q;
      end
      cause_exccode_d = exc_code;
      status_exl_d    = 1'b1;
      if (badv_we) begin
        badvaddr_d = badv_val;
      end else begin
        badvaddr_d = badvaddr_q;
      end
    end else begin
      if (mtc0_go) begin
        case (f_rd)
`ifdef WB_TIMER_INT_EN
          5'd9:  count_d = f_result;
          5'd11: begin
            compare_d = f_result;
            ti_d      = 1'b0;
          end
`endif
          5'd12: begin
            status_im_d  = f_result[15:8];
            status_exl_d = f_result[1];
            status_ie_d  = f_result[0];
          end
          5'd13:   cause_ip_sw_d = f_result[9:8];
          5'd14:   epc_d = f_result;
          default: epc_d = epc_q;
        endcase
      end else begin
        epc_d = epc_q;
      end
      if (eret_go) begin
        status_exl_d = 1'b0;
      end else begin
        status_exl_d = status_exl_d;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q      <= 1'b0;
      bus_q           <= {122{1'b0}};
      badvaddr_q      <= 32'd0;
      count_q         <= 32'd0;
      compare_q       <= 32'd0;
      tick_q          <= 1'b0;
      ti_q            <= 1'b0;
      status_im_q     <= 8'd0;
      status_exl_q    <= 1'b0;
      status_ie_q     <= 1'b0;
      cause_bd_q      <= 1'b0;
      cause_ip_hw_q   <= 6'd0;
      cause_ip_sw_q   <= 2'd0;
      cause_exccode_q <= 5'd0;
      epc_q           <= 32'd0;
    end else begin
      ws_valid_q      <= ws_valid_d;
      bus_q           <= bus_d;
      badvaddr_q      <= badvaddr_d;
      count_q         <= count_d;
      compare_q       <= compare_d;
      tick_q          <= tick_d;
      ti_q            <= ti_d;
      status_im_q     <= status_im_d;
      status_exl_q    <= status_exl_d;
      status_ie_q     <= status_ie_d;
      cause_bd_q      <= cause_bd_d;
      cause_ip_hw_q   <= cause_ip_hw_d;
      cause_ip_sw_q   <= cause_ip_sw_d;
      cause_exccode_q <= cause_exccode_d;
      epc_q           <= epc_d;
    end
  end

  assign ws_allowin   = 1'b1;
  assign exc_flush    = live & (exc | f_eret);
  // Only ERET redirects to EPC; everything else (including idle) shows the vector.
  assign exc_target   = eret_go ? epc_q : EXC_ENTRY;
  assign ws_to_rf_bus = {rf_we, f_dest, rf_wdata};
  assign ws_to_ds_bus = rf_we ? {1'b1, f_dest, rf_wdata} : 38'd0;

  assign debug_wb_pc       = f_pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = f_dest;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  localparam logic [31:0] ENT = 32'hBFC0_0380;
  localparam logic [11:0] F_OV     = 12'h800;
  localparam logic [11:0] F_ADES   = 12'h400;
  localparam logic [11:0] F_ADELIF = 12'h200;
  localparam logic [11:0] F_ADELLD = 12'h100;
  localparam logic [11:0] F_RI     = 12'h080;
  localparam logic [11:0] F_BP     = 12'h040;
  localparam logic [11:0] F_FLUSH  = 12'h020;
  localparam logic [11:0] F_BD     = 12'h010;
  localparam logic [11:0] F_ERET   = 12'h008;
  localparam logic [11:0] F_SYS    = 12'h004;
  localparam logic [11:0] F_MFC0   = 12'h002;
  localparam logic [11:0] F_MTC0   = 12'h001;
  localparam logic [31:0] PC0      = 32'hBFC0_1000;

  logic         clk = 1'b0;
  logic         reset;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [121:0] ms_to_ws_bus;
  logic [5:0]   ext_int_in;
  logic [37:0]  ws_to_rf_bus;
  logic [37:0]  ws_to_ds_bus;
  logic         exc_flush;
  logic [31:0]  exc_target;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ext_int_in        (ext_int_in),
    .ws_to_rf_bus      (ws_to_rf_bus),
    .ws_to_ds_bus      (ws_to_ds_bus),
    .exc_flush         (exc_flush),
    .exc_target        (exc_target),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  typedef struct {
    logic [121:0] bus;
    logic         valid;
    logic         exp_we;
    logic [4:0]   exp_waddr;
    logic [31:0]  exp_wdata;
    logic [31:0]  mask;
    logic         exp_flush;
    logic [31:0]  exp_target;
    string        name;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [121:0] mk(input logic [11:0] fl, input logic [31:0] badv,
                                      input logic [2:0] sel, input logic [4:0] rd,
                                      input logic gwe, input logic [4:0] dest,
                                      input logic [31:0] res, input logic [31:0] pc);
    return {fl[11], badv, fl[10], fl[9], fl[8], fl[7], fl[6], fl[5], fl[4],
            fl[3], fl[2], fl[1], fl[0], sel, rd, gwe, dest, res, pc};
  endfunction

  function automatic logic [121:0] mfc(input logic [4:0] rd);
    return mk(F_MFC0, 32'd0, 3'd0, rd, 1'b1, 5'd2, 32'hDEAD_BEEF, PC0);
  endfunction

  function automatic logic [121:0] mtc(input logic [4:0] rd, input logic [31:0] val);
    return mk(F_MTC0, 32'd0, 3'd0, rd, 1'b0, 5'd0, val, PC0);
  endfunction

  task automatic add(input logic [121:0] bus, input logic valid, input logic we,
                     input logic [4:0] waddr, input logic [31:0] wdata,
                     input logic flush, input logic [31:0] target, input string name,
                     input logic [31:0] mask = 32'hFFFF_FFFF);
    vec_t v;
    v.bus = bus; v.valid = valid; v.exp_we = we; v.exp_waddr = waddr;
    v.exp_wdata = wdata; v.mask = mask; v.exp_flush = flush;
    v.exp_target = target; v.name = name;
    vq.push_back(v);
  endtask

  // Convenience: an MFC0 into r2 expected to read val (under mask).
  task automatic add_rd(input logic [4:0] rd, input logic [31:0] val, input string name,
                        input logic [31:0] mask = 32'hFFFF_FFFF);
    add(mfc(rd), 1'b1, 1'b1, 5'd2, val, 1'b0, ENT, name, mask);
  endtask

  task automatic add_wr(input logic [4:0] rd, input logic [31:0] val, input string name);
    add(mtc(rd, val), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, ENT, name);
  endtask

  task automatic run_all();
    vec_t v;
    logic [31:0] pc;
    while (vq.size() > 0) begin
      v = vq.pop_front();
      pc = v.bus[31:0];
      @(negedge clk);
      ms_to_ws_valid = v.valid;
      ms_to_ws_bus   = v.bus;
      @(posedge clk);
      #1;
      ms_to_ws_valid = 1'b0;
      chk({v.name, ".flush"}, {63'd0, exc_flush}, {63'd0, v.exp_flush});
      if (v.exp_flush) chk({v.name, ".target"}, {32'd0, exc_target}, {32'd0, v.exp_target});
      chk({v.name, ".we"}, {63'd0, ws_to_rf_bus[37]}, {63'd0, v.exp_we});
      if (v.exp_we) begin
        chk({v.name, ".waddr"}, {59'd0, ws_to_rf_bus[36:32]}, {59'd0, v.exp_waddr});
        chk({v.name, ".wdata"}, {32'd0, ws_to_rf_bus[31:0] & v.mask}, {32'd0, v.exp_wdata});
        chk({v.name, ".ds"}, {26'd0, ws_to_ds_bus}, {26'd0, ws_to_rf_bus});
        chk({v.name, ".dbg_wen"}, {60'd0, debug_wb_rf_wen}, 64'hF);
        chk({v.name, ".dbg_pc"}, {32'd0, debug_wb_pc}, {32'd0, pc});
        chk({v.name, ".dbg_wnum"}, {59'd0, debug_wb_rf_wnum}, {59'd0, v.exp_waddr});
      end else begin
        chk({v.name, ".ds_zero"}, {26'd0, ws_to_ds_bus}, 64'd0);
        chk({v.name, ".dbg_wen0"}, {60'd0, debug_wb_rf_wen}, 64'd0);
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus = {122{1'b0}};
    ext_int_in = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.allowin", {63'd0, ws_allowin}, 64'd1);
    chk("rst.flush", {63'd0, exc_flush}, 64'd0);
    chk("rst.target", {32'd0, exc_target}, {32'd0, ENT});
    chk("rst.rf_bus", {26'd0, ws_to_rf_bus}, 64'd0);
    chk("rst.ds_bus", {26'd0, ws_to_ds_bus}, 64'd0);
    chk("rst.dbg_pc", {32'd0, debug_wb_pc}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Main table. Compare is parked far away first so the optional timer stays quiet.
    add_wr(5'd11, 32'hFFFF_FFFF, "mtc0_compare");
    add(mk(12'd0, 32'd0, 3'd0, 5'd0, 1'b1, 5'd5, 32'h1234, 32'hBFC0_0010), 1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, ENT, "addu");
    add_rd(5'd12, 32'h0040_0000, "status_reset");
    add(mk(F_SYS | F_BD, 32'd0, 3'd0, 5'd0, 1'b0, 5'd0, 32'd0, 32'hBFC0_0100), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, ENT, "syscall");
    add_rd(5'd14, 32'hBFC0_00FC, "epc_bd");
    add_rd(5'd13, 32'h8000_0020, "cause_sys");
    add_rd(5'd12, 32'h0040_0002, "status_exl");
    add_wr(5'd12, 32'h0000_FF01, "mtc0_status");
    add_rd(5'd12, 32'h0040_FF01, "status_rd");
    add(mk(F_ADELLD, 32'h3, 3'd0, 5'd0, 1'b1, 5'd4, 32'h77, 32'hBFC0_0300), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, ENT, "adel_ld");
    add_rd(5'd8, 32'h3, "badvaddr_ld");
    add_rd(5'd13, 32'h0000_0010, "cause_adel");
    add_rd(5'd14, 32'hBFC0_0300, "epc_adel");
    add_rd(5'd12, 32'h0040_FF03, "status_exl2");
    add_wr(5'd14, 32'hBFC0_0200, "mtc0_epc");
    add(mk(F_ERET, 32'd0, 3'd0, 5'd0, 1'b0, 5'd0, 32'd0, PC0), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 32'hBFC0_0200, "eret");
    add_rd(5'd12, 32'h0040_FF01, "status_eret");
    add(mk(F_FLUSH | F_SYS, 32'd0, 3'd0, 5'd0, 1'b1, 5'd6, 32'h55, 32'hBFC0_0700), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, ENT, "flushed_sys");
    add(mk(F_SYS, 32'd0, 3'd0, 5'd0, 1'b1, 5'd6, 32'h55, 32'hBFC0_0700), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, ENT, "invalid_sys");
    add_rd(5'd13, 32'h0000_0010, "cause_kept");
    add_rd(5'd14, 32'hBFC0_0200, "epc_kept");
    add(mk(F_RI | F_OV | F_SYS | F_BP, 32'd0, 3'd0, 5'd0, 1'b1, 5'd3, 32'h1, 32'hBFC0_0400), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, ENT, "prio_ri");
    add_rd(5'd13, 32'h0000_0028, "cause_ri");
    add(mk(F_BP | F_BD | F_MTC0, 32'd0, 3'd0, 5'd14, 1'b0, 5'd0, 32'h1111_1111, 32'hBFC0_0500), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, ENT, "bp_nested");
    add_rd(5'd14, 32'hBFC0_0400, "epc_nested");
    add_rd(5'd13, 32'h0000_0024, "cause_bp");
    add(mk(F_ADELIF | F_ADES, 32'h55, 3'd0, 5'd0, 1'b1, 5'd3, 32'd0, 32'h0000_0002), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, ENT, "adel_if");
    add_rd(5'd8, 32'h2, "badvaddr_if");
    add_rd(5'd15, 32'h0, "unmapped");
    add_wr(5'd13, 32'hFFFF_FFFF, "mtc0_cause");
    add_rd(5'd13, 32'h0000_0310, "cause_ip_sw");
    add(mk(F_ERET, 32'd0, 3'd0, 5'd0, 1'b0, 5'd0, 32'd0, PC0), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 32'hBFC0_0400, "eret2");
    add(mk(12'd0, 32'd0, 3'd0, 5'd0, 1'b1, 5'd7, 32'h9, 32'hBFC0_0600), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, ENT, "sw_int");
    add_rd(5'd13, 32'h0000_0300, "cause_int");
    add_rd(5'd14, 32'hBFC0_0600, "epc_int");
    add_wr(5'd13, 32'h0, "clr_ip");
    add_wr(5'd12, 32'hFFFF_FFFF, "status_all");
    add_rd(5'd12, 32'h0040_FF03, "status_mask");
    add_wr(5'd8, 32'h99, "badv_ro");
    add_rd(5'd8, 32'h2, "badv_kept");
    add(mk(F_MTC0, 32'd0, 3'd1, 5'd14, 1'b0, 5'd0, 32'h1234_5678, PC0), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, ENT, "mtc0_sel1");
    add_rd(5'd14, 32'hBFC0_0600, "epc_sel");
    run_all();

    // Reset in the middle of an MTC0: the write must not land.
    @(negedge clk);
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus = mtc(5'd14, 32'h0000_1234);
    reset = 1'b1;
    @(posedge clk);
    #1;
    ms_to_ws_valid = 1'b0;
    chk("midrst.flush", {63'd0, exc_flush}, 64'd0);
    chk("midrst.target", {32'd0, exc_target}, {32'd0, ENT});
    chk("midrst.rf_bus", {26'd0, ws_to_rf_bus}, 64'd0);
    chk("midrst.dbg_pc", {32'd0, debug_wb_pc}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    add_rd(5'd14, 32'h0, "midrst_epc");
    add_rd(5'd12, 32'h0040_0000, "midrst_status");
    add_rd(5'd8, 32'h0, "midrst_badv");
    run_all();

    // External interrupt line 0 -> IP2.
    ext_int_in = 6'b000001;
    add_wr(5'd12, 32'h0000_0401, "ext_status");
    add(mk(12'd0, 32'd0, 3'd0, 5'd0, 1'b1, 5'd9, 32'h5, 32'hBFC0_0800), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, ENT, "ext_int");
    add_rd(5'd13, 32'h0000_0400, "ext_cause", 32'h0000_07FC);
    add_rd(5'd14, 32'hBFC0_0800, "ext_epc");
    run_all();
    ext_int_in = 6'd0;

`ifdef WB_TIMER_INT_EN
    pulse_reset();
    add_wr(5'd11, 32'd10, "tmr_compare");
    add_wr(5'd12, 32'h0000_8001, "tmr_status");
    run_all();
    repeat (40) @(negedge clk);
    add(mk(12'd0, 32'd0, 3'd0, 5'd0, 1'b1, 5'd9, 32'h5, 32'hBFC0_0900), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, ENT, "tmr_int");
    add_rd(5'd13, 32'h4000_0000, "tmr_cause", 32'h4000_007C);
    add_wr(5'd11, 32'h7FFF_FFFF, "tmr_clr");
    add_rd(5'd13, 32'h0, "tmr_ti_clr", 32'h4000_0000);
    add_rd(5'd11, 32'h7FFF_FFFF, "tmr_cmp_rd");
    add_wr(5'd9, 32'd100, "tmr_count_wr");
    add_rd(5'd9, 32'd100, "tmr_count_rd");
    run_all();
`else
    add_wr(5'd9, 32'd100, "nt_count_wr");
    add_rd(5'd9, 32'd0, "nt_count_rd");
    add_wr(5'd11, 32'd7, "nt_compare_wr");
    add_rd(5'd11, 32'd0, "nt_compare_rd");
    run_all();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
